// File: rtl/mem.sv
// Byte-addressable 1 KiB data memory for the CPU MEM stage.
// Loads are combinational with sign/zero extension. Stores are byte-masked
// and take effect on the rising edge. Synchronous reset restores the preload image.
module mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [9:0]  addr,
  input  logic [31:0] data_in,
  input  logic        u,
  input  logic [1:0]  mem_inst_type,
  output logic [31:0] data_out
);

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned AW     = 10;
  localparam int unsigned DW     = 32;
  localparam int unsigned BW     = 8;
  localparam int unsigned LANES  = DW / BW;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  // Byte storage, little-endian
  logic [BW-1:0] mem_q [DEPTH];

  // Aligned base addresses for halfword and word accesses
  logic [AW-1:0] half_base;
  logic [AW-1:0] word_base;

  // Per-lane write targets, enables and data
  logic [AW-1:0]    lane_addr [LANES];
  logic [LANES-1:0] lane_en;
  logic [BW-1:0]    lane_data [LANES];

  // Raw bytes read from the word-aligned group around addr
  logic [BW-1:0] rd_byte;
  logic [BW-1:0] rd_half_lo;
  logic [BW-1:0] rd_half_hi;
  logic [BW-1:0] rd_word [LANES];

  // Fixed preload image, one byte at a time
  function automatic logic [BW-1:0] preload_byte(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    logic [BW-1:0] b;
    case (a[AW-1:2])
      8'd0:    w = 32'h0000_0011;
      8'd1:    w = 32'h0000_0009;
      8'd2:    w = 32'h0000_0019;
      8'd3:    w = 32'h8000_FF80;
      8'd4:    w = 32'h1234_5678;
      8'd5:    w = 32'hFFFF_FFFF;
      8'd6:    w = 32'h0000_0000;
      default: w = 32'h0000_0000;
    endcase
    case (a[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Alignment: halfwords drop addr[0], words drop addr[1:0]
  always_comb begin
    half_base = {addr[AW-1:1], 1'b0};
    word_base = {addr[AW-1:2], 2'b00};
  end

  // Store lane selection: which bytes change and with what value
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i] = word_base | AW'(i);
      lane_data[i] = data_in[i*BW +: BW];
    end
    case (mem_inst_type)
      SZ_BYTE: begin
        lane_en[0]   = MemWrite;
        lane_addr[0] = addr;
        lane_data[0] = data_in[7:0];
      end
      SZ_HALF: begin
        lane_en[1:0] = {2{MemWrite}};
        lane_addr[0] = half_base;
        lane_addr[1] = half_base | AW'(1);
        lane_data[0] = data_in[7:0];
        lane_data[1] = data_in[15:8];
      end
      default: begin
        lane_en = {LANES{MemWrite}};
      end
    endcase
  end

  // Array update: reset restores the image and overrides any store
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= preload_byte(AW'(i));
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          mem_q[lane_addr[i]] <= lane_data[i];
        end
      end
    end
  end

  // Fetch the raw bytes for every access size
  always_comb begin
    rd_byte    = mem_q[addr];
    rd_half_lo = mem_q[half_base];
    rd_half_hi = mem_q[half_base | AW'(1)];
    for (int i = 0; i < LANES; i++) begin
      rd_word[i] = mem_q[word_base | AW'(i)];
    end
  end

  // Load result: size select plus sign or zero extension
  always_comb begin
    data_out = '0;
    case (mem_inst_type)
      SZ_BYTE: begin
        data_out = {{(DW-8){rd_byte[7] & ~u}}, rd_byte};
      end
      SZ_HALF: begin
        data_out = {{(DW-16){rd_half_hi[7] & ~u}}, rd_half_hi, rd_half_lo};
      end
      default: begin
        data_out = {rd_word[3], rd_word[2], rd_word[1], rd_word[0]};
      end
    endcase
  end

endmodule

// File: tb/tb_mem.sv
// Directed self-checking bench for the MEM-stage data memory.
module tb_mem;

  logic        clk;
  logic        rst;
  logic        MemWrite;
  logic [9:0]  addr;
  logic [31:0] data_in;
  logic        u;
  logic [1:0]  mem_inst_type;
  logic [31:0] data_out;

  int checks;
  int errors;

  mem dut (
    .clk           (clk),
    .rst           (rst),
    .MemWrite      (MemWrite),
    .addr          (addr),
    .data_in       (data_in),
    .u             (u),
    .mem_inst_type (mem_inst_type),
    .data_out      (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expected);
    checks++;
    assert (data_out === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, data_out, expected);
    end
  endtask

  // Set up a read and let the combinational path settle
  task automatic rd(input logic [9:0] a, input logic [1:0] t, input logic uu);
    addr = a;
    mem_inst_type = t;
    u = uu;
    #1;
  endtask

  // One rising edge, returning to the falling edge to drive again
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [9:0] a, input logic [1:0] t, input logic [31:0] d);
    addr = a;
    mem_inst_type = t;
    data_in = d;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    MemWrite = 1'b0;
    addr = '0;
    data_in = '0;
    u = 1'b0;
    mem_inst_type = 2'd2;
    tick();
    rst = 1'b0;

    // Preload image, word reads
    rd(10'd0,  2'd2, 1'b0); check("pre_0",  32'h0000_0011);
    rd(10'd4,  2'd2, 1'b0); check("pre_4",  32'h0000_0009);
    rd(10'd8,  2'd2, 1'b0); check("pre_8",  32'h0000_0019);
    rd(10'd12, 2'd2, 1'b0); check("pre_12", 32'h8000_FF80);
    rd(10'd16, 2'd2, 1'b0); check("pre_16", 32'h1234_5678);
    rd(10'd20, 2'd2, 1'b0); check("pre_20", 32'hFFFF_FFFF);
    rd(10'd24, 2'd2, 1'b0); check("pre_24", 32'h0000_0000);
    rd(10'd16, 2'd3, 1'b1); check("type3_16", 32'h1234_5678);

    // Sign and zero extension
    rd(10'd12, 2'd0, 1'b0); check("b12_s",  32'hFFFF_FF80);
    rd(10'd12, 2'd0, 1'b1); check("b12_u",  32'h0000_0080);
    rd(10'd14, 2'd1, 1'b0); check("h14_s",  32'hFFFF_8000);
    rd(10'd14, 2'd1, 1'b1); check("h14_u",  32'h0000_8000);
    rd(10'd12, 2'd1, 1'b0); check("h12_s",  32'hFFFF_FF80);
    rd(10'd13, 2'd0, 1'b0); check("b13_s",  32'hFFFF_FFFF);
    rd(10'd17, 2'd0, 1'b0); check("b17_s",  32'h0000_0056);
    rd(10'd20, 2'd1, 1'b0); check("h20_s",  32'hFFFF_FFFF);
    rd(10'd15, 2'd0, 1'b1); check("b15_u",  32'h0000_0080);

    // Word store: invisible before the edge, visible after
    addr = 10'd32; mem_inst_type = 2'd2; data_in = 32'hDEAD_BEEF; MemWrite = 1'b1;
    #1; check("no_bypass", 32'h0000_0000);
    tick();
    MemWrite = 1'b0;
    rd(10'd32, 2'd2, 1'b0); check("w32_store", 32'hDEAD_BEEF);
    rd(10'd33, 2'd0, 1'b1); check("b33_u",     32'h0000_00BE);

    // Narrow stores overlaid on the word
    wr(10'd34, 2'd0, 32'h1111_11AA);
    rd(10'd32, 2'd2, 1'b0); check("w32_b34", 32'hDEAA_BEEF);
    wr(10'd32, 2'd1, 32'hFFFF_1234);
    rd(10'd32, 2'd2, 1'b0); check("w32_h32", 32'hDEAA_1234);
    rd(10'd36, 2'd2, 1'b0); check("w36_same", 32'h0000_0000);

    // Alignment
    rd(10'd35, 2'd2, 1'b0); check("w35_align", 32'hDEAA_1234);
    rd(10'd33, 2'd1, 1'b0); check("h33_align", 32'h0000_1234);
    rd(10'd35, 2'd1, 1'b0); check("h35_align", 32'hFFFF_DEAA);

    // Top-of-memory boundary
    wr(10'd1020, 2'd2, 32'hCAFE_F00D);
    rd(10'd1020, 2'd2, 1'b0); check("w1020",   32'hCAFE_F00D);
    rd(10'd1023, 2'd0, 1'b0); check("b1023_s", 32'hFFFF_FFCA);
    rd(10'd0,    2'd2, 1'b0); check("w0_kept", 32'h0000_0011);

    // Reset beats a simultaneous store and wipes earlier stores
    addr = 10'd0; mem_inst_type = 2'd2; data_in = 32'h5555_5555;
    MemWrite = 1'b1; rst = 1'b1;
    tick();
    MemWrite = 1'b0; rst = 1'b0;
    rd(10'd0,    2'd2, 1'b0); check("rst_w0",    32'h0000_0011);
    rd(10'd32,   2'd2, 1'b0); check("rst_w32",   32'h0000_0000);
    rd(10'd1020, 2'd2, 1'b0); check("rst_w1020", 32'h0000_0000);
    rd(10'd12,   2'd2, 1'b0); check("rst_w12",   32'h8000_FF80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
